// File: rtl/tile_layer_mixer_if.sv
// Pixel-side bus of tile_layer_mixer: per-layer planar graphics and attributes
// in, the daisy-chained PRI/CLI/DTI stream in, and the mixed pixel out.
interface tile_layer_mixer_if #(
  parameter int LAYERS = 2,
  parameter int BPP    = 3,
  parameter int CLW    = 8,
  parameter int PRW    = 3
);
  logic                    FLIP;
  logic [LAYERS-1:0]       LOAD;
  logic [LAYERS-1:0]       LAYER_EN;
  logic [LAYERS*BPP*4-1:0] GDI;
  logic [LAYERS*CLW-1:0]   CLI_L;
  logic [LAYERS*PRW-1:0]   PRI_L;
  logic [LAYERS*2-1:0]     FINE;
  logic [PRW-1:0]          PRI;
  logic [CLW-1:0]          CLI;
  logic [BPP-1:0]          DTI;
  logic [PRW-1:0]          PRO;
  logic [CLW-1:0]          CLO;
  logic [BPP-1:0]          DTO;
  logic [LAYERS-1:0]       ACTIVE;

  modport master (
    output FLIP, LOAD, LAYER_EN, GDI, CLI_L, PRI_L, FINE, PRI, CLI, DTI,
    input  PRO, CLO, DTO, ACTIVE
  );

  modport slave (
    input  FLIP, LOAD, LAYER_EN, GDI, CLI_L, PRI_L, FINE, PRI, CLI, DTI,
    output PRO, CLO, DTO, ACTIVE
  );
endinterface

// File: rtl/tile_layer_mixer.sv
// Multi-layer tile pixel serialiser with per-layer fine-scroll delay and
// priority mixing over the upstream PRI/CLI/DTI chain.
module tile_layer_mixer #(
  parameter int             LAYERS = 2,
  parameter int             BPP    = 3,
  parameter int             CLW    = 8,
  parameter int             PRW    = 3,
  parameter logic [BPP-1:0] TRANSP = {BPP{1'b1}}
) (
  input logic               CLK_6M,
  input logic               RST_N,
  tile_layer_mixer_if.slave bus
);

  typedef struct packed {
    logic [BPP-1:0] dt;
    logic [CLW-1:0] cl;
    logic [PRW-1:0] pr;
  } pix_t;

  localparam pix_t PIX_IDLE = '{dt: TRANSP, cl: '0, pr: '0};

  logic [BPP*4-1:0]  gd_q   [LAYERS];
  logic [CLW-1:0]    cl_q   [LAYERS];
  logic [PRW-1:0]    pr_q   [LAYERS];
  logic [1:0]        idx_q  [LAYERS];
  logic [LAYERS-1:0] active_q;

  pix_t s1    [LAYERS];
  pix_t dly_q [LAYERS][3];
  pix_t tap   [LAYERS];
  pix_t chain_q;
  pix_t mix;
  pix_t out_q;

  // Stage 1: group latch and pixel index per layer.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      active_q <= '0;
      for (int l = 0; l < LAYERS; l++) begin
        for (int p = 0; p < BPP; p++) gd_q[l][p*4 +: 4] <= {4{TRANSP[p]}};
        cl_q[l]  <= '0;
        pr_q[l]  <= '0;
        idx_q[l] <= 2'd3;
      end
    end else begin
      for (int l = 0; l < LAYERS; l++) begin
        if (bus.LOAD[l]) begin
          gd_q[l]     <= bus.GDI[l*BPP*4 +: BPP*4];
          cl_q[l]     <= bus.CLI_L[l*CLW +: CLW];
          pr_q[l]     <= bus.PRI_L[l*PRW +: PRW];
          idx_q[l]    <= 2'd0;
          active_q[l] <= 1'b1;
        end else if (active_q[l] && idx_q[l] != 2'd3) begin
          idx_q[l] <= idx_q[l] + 2'd1;
        end else if (idx_q[l] == 2'd3) begin
          active_q[l] <= 1'b0;
        end
      end
    end
  end

  // Pixel extraction; FLIP is live so a mid-group change takes effect at once.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic [3:0] nib;
    nib = '0;
    for (int l = 0; l < LAYERS; l++) begin
      s1[l].cl = cl_q[l];
      s1[l].pr = pr_q[l];
      s1[l].dt = TRANSP;
      if (active_q[l]) begin
        for (int p = 0; p < BPP; p++) begin
          nib = gd_q[l][p*4 +: 4];
          s1[l].dt[p] = bus.FLIP ? nib[idx_q[l]] : nib[~idx_q[l]];
        end
      end
    end
  end

  // Fine-scroll delay lines and the upstream chain register.
  // NOTE: the delay lines are reset to transparent so no stale pixel from before
  // a reset can surface on a delayed tap afterwards.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      chain_q <= PIX_IDLE;
      for (int l = 0; l < LAYERS; l++)
        for (int s = 0; s < 3; s++) dly_q[l][s] <= PIX_IDLE;
    end else begin
      chain_q <= '{dt: bus.DTI, cl: bus.CLI, pr: bus.PRI};
      for (int l = 0; l < LAYERS; l++) begin
        dly_q[l][0] <= s1[l];
        dly_q[l][1] <= dly_q[l][0];
        dly_q[l][2] <= dly_q[l][1];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LAYERS; l++) begin
      tap[l] = s1[l];
      case (bus.FINE[l*2 +: 2])
        2'd1:    tap[l] = dly_q[l][0];
        2'd2:    tap[l] = dly_q[l][1];
        2'd3:    tap[l] = dly_q[l][2];
        default: tap[l] = s1[l];
      endcase
    end
  end

  // Ascending layer order with >= hands priority ties to the higher index.
  always_comb begin
    mix = chain_q;
    for (int l = 0; l < LAYERS; l++) begin
      if (bus.LAYER_EN[l] && tap[l].dt != TRANSP && tap[l].pr >= mix.pr)
        mix = tap[l];
    end
  end

  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) out_q <= '0;
    else        out_q <= mix;
  end

  assign bus.PRO    = out_q.pr;
  assign bus.CLO    = out_q.cl;
  assign bus.DTO    = out_q.dt;
  assign bus.ACTIVE = active_q;

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Directed bench for tile_layer_mixer: expectations are queued with the edge
// number they belong to and checked by a monitor after that edge.
module tb_tile_layer_mixer;
  localparam int LAYERS = 2;
  localparam int BPP    = 3;
  localparam int CLW    = 8;
  localparam int PRW    = 3;

  typedef struct {
    int         e;
    string      tag;
    logic [2:0] pr;
    logic [7:0] cl;
    logic [2:0] dt;
    logic [1:0] act;
    bit         co;
    bit         ca;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;
  int   k;
  int   l1_px[4] = '{2, 3, 0, 1};

  tile_layer_mixer_if #(.LAYERS(LAYERS), .BPP(BPP), .CLW(CLW), .PRW(PRW)) bus ();

  tile_layer_mixer #(.LAYERS(LAYERS), .BPP(BPP), .CLW(CLW), .PRW(PRW)) dut (
    .CLK_6M (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic exp_out(input int e, input string tag, input logic [2:0] pr,
                         input logic [7:0] cl, input logic [2:0] dt);
    exp_t t;
    t.e = e; t.tag = tag; t.pr = pr; t.cl = cl; t.dt = dt; t.act = '0;
    t.co = 1'b1; t.ca = 1'b0;
    sb.push_back(t);
  endtask

  task automatic exp_act(input int e, input string tag, input logic [1:0] act);
    exp_t t;
    t.e = e; t.tag = tag; t.pr = '0; t.cl = '0; t.dt = '0; t.act = act;
    t.co = 1'b0; t.ca = 1'b1;
    sb.push_back(t);
  endtask

  task automatic check_now(input string tag);
    checks++;
    assert ({bus.PRO, bus.CLO, bus.DTO, bus.ACTIVE} === 16'h0000) else begin
      errors++;
      $error("FAIL %s: observed pr=%0d cl=%h dt=%0d act=%b expected all zero",
             tag, bus.PRO, bus.CLO, bus.DTO, bus.ACTIVE);
    end
  endtask

  task automatic pulse(input logic [1:0] ld);
    bus.LOAD = ld;
    @(negedge clk);
    bus.LOAD = 2'b00;
  endtask

  // Monitor: sample 1 ns after each rising edge, compare every entry due now.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].e == edge_n) begin
          if (sb[i].co) begin
            checks++;
            assert ({bus.PRO, bus.CLO, bus.DTO} === {sb[i].pr, sb[i].cl, sb[i].dt}) else begin
              errors++;
              $error("FAIL %s @edge %0d: observed pr=%0d cl=%h dt=%0d expected pr=%0d cl=%h dt=%0d",
                     sb[i].tag, edge_n, bus.PRO, bus.CLO, bus.DTO, sb[i].pr, sb[i].cl, sb[i].dt);
            end
          end
          if (sb[i].ca) begin
            checks++;
            assert (bus.ACTIVE === sb[i].act) else begin
              errors++;
              $error("FAIL %s @edge %0d: observed active=%b expected active=%b",
                     sb[i].tag, edge_n, bus.ACTIVE, sb[i].act);
            end
          end
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.FLIP     = 1'b0;
    bus.LOAD     = 2'b00;
    bus.LAYER_EN = 2'b11;
    bus.GDI      = '0;
    bus.CLI_L    = '0;
    bus.PRI_L    = '0;
    bus.FINE     = '0;
    bus.PRI      = 3'd0;
    bus.CLI      = 8'hA0;
    bus.DTI      = 3'd5;
    repeat (3) @(negedge clk);
    check_now("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Serialisation, FLIP=0
    bus.GDI[11:0]  = 12'h0CA;
    bus.CLI_L[7:0] = 8'h15;
    bus.PRI_L[2:0] = 3'd3;
    k = edge_n + 1;
    exp_act(k, "t1_act", 2'b01);
    for (int j = 0; j < 4; j++) begin
      exp_out(k + 1 + j, "t1_pix", 3'd3, 8'h15, 3'(3 - j));
      exp_act(k + 1 + j, "t1_act", (j < 3) ? 2'b01 : 2'b00);
    end
    exp_out(k + 5, "t1_chain", 3'd0, 8'hA0, 3'd5);
    pulse(2'b01);
    repeat (5) @(negedge clk);

    // FLIP with gapless loads every 4th cycle
    bus.FLIP = 1'b1;
    k = edge_n + 1;
    for (int j = 0; j < 12; j++) exp_out(k + 1 + j, "t2_flip", 3'd3, 8'h15, 3'(j % 4));
    exp_out(k + 13, "t2_end", 3'd0, 8'hA0, 3'd5);
    for (int j = 0; j < 12; j++) begin
      bus.LOAD = (j % 4 == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    bus.LOAD = 2'b00;
    repeat (3) @(negedge clk);
    bus.FLIP = 1'b0;

    // Fully transparent group leaves the chain visible
    bus.PRI        = 3'd2;
    bus.GDI[11:0]  = 12'hFFF;
    bus.PRI_L[2:0] = 3'd7;
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) exp_out(k + 1 + j, "t3_transp", 3'd2, 8'hA0, 3'd5);
    pulse(2'b01);
    repeat (4) @(negedge clk);

    // Disabled layer; chain colour varies per cycle to show the 1-cycle delay
    bus.LAYER_EN  = 2'b10;
    bus.GDI[11:0] = 12'h0CA;
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) begin
      bus.LOAD = (j == 0) ? 2'b01 : 2'b00;
      bus.CLI  = 8'hA0 + 8'(j);
      exp_out(k + 1 + j, "t3_disable", 3'd2, 8'hA0 + 8'(j), 3'd5);
      @(negedge clk);
    end
    bus.LOAD = 2'b00;
    bus.CLI  = 8'hA0;
    repeat (2) @(negedge clk);
    bus.LAYER_EN = 2'b11;

    // Priority: tie goes to layer 1
    bus.PRI   = 3'd0;
    bus.GDI   = {12'h0C5, 12'h0CA};
    bus.CLI_L = {8'h2B, 8'h15};
    bus.PRI_L = {3'd4, 3'd4};
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) exp_out(k + 1 + j, "t4_tie", 3'd4, 8'h2B, 3'(l1_px[j]));
    pulse(2'b11);
    repeat (4) @(negedge clk);

    // Layer 0 higher priority
    bus.PRI_L = {3'd2, 3'd4};
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) exp_out(k + 1 + j, "t4_l0", 3'd4, 8'h15, 3'(3 - j));
    pulse(2'b11);
    repeat (4) @(negedge clk);

    // Chain above both layers
    bus.PRI   = 3'd5;
    bus.PRI_L = {3'd4, 3'd4};
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) exp_out(k + 1 + j, "t4_chain", 3'd5, 8'hA0, 3'd5);
    pulse(2'b11);
    repeat (4) @(negedge clk);

    // Transparent chain pixel still holds by priority
    bus.PRI   = 3'd6;
    bus.DTI   = 3'd7;
    bus.PRI_L = {3'd2, 3'd4};
    k = edge_n + 1;
    for (int j = 0; j < 4; j++) exp_out(k + 1 + j, "t4_tchain", 3'd6, 8'hA0, 3'd7);
    pulse(2'b11);
    repeat (4) @(negedge clk);
    bus.PRI = 3'd0;
    bus.DTI = 3'd5;
    repeat (4) @(negedge clk);

    // Fine scroll: layer0 delayed 2, layer1 undelayed
    bus.FINE = {2'd0, 2'd2};
    k = edge_n + 1;
    exp_out(k + 1, "t5_l1", 3'd2, 8'h2B, 3'd2);
    exp_out(k + 2, "t5_l1", 3'd2, 8'h2B, 3'd3);
    for (int j = 0; j < 4; j++) exp_out(k + 3 + j, "t5_l0", 3'd4, 8'h15, 3'(3 - j));
    exp_out(k + 7, "t5_chain", 3'd0, 8'hA0, 3'd5);
    pulse(2'b11);
    repeat (8) @(negedge clk);

    // Reset mid-group with layer0 on the deepest tap
    bus.FINE       = {2'd0, 2'd3};
    bus.PRI        = 3'd1;
    bus.PRI_L[2:0] = 3'd4;
    k = edge_n + 1;
    exp_out(k + 1, "t6_pre", 3'd1, 8'hA0, 3'd5);
    exp_out(k + 2, "t6_pre", 3'd1, 8'hA0, 3'd5);
    pulse(2'b01);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_now("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = edge_n + 1;
    exp_out(k, "t6_first", 3'd0, 8'h00, 3'd7);
    exp_act(k, "t6_act", 2'b00);
    for (int j = 1; j <= 4; j++) exp_out(k + j, "t6_chain", 3'd1, 8'hA0, 3'd5);
    repeat (6) @(negedge clk);

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never compared (now edge %0d)",
               sb[0].tag, sb[0].e, edge_n);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tile_layer_mixer.md
Name: tile_layer_mixer

Overview:
Parametrised successor to the single-layer tile pixel generator. It serialises planar tile graphics for LAYERS independent layers, with per-layer fine-scroll delay, group flip, transparency and enable. It then priority-mixes those layers over the daisy-chained PRI/CLI/DTI stream from the upstream generator. The block sits between the tile RAM/ROM fetch logic and the tilemap palette PROM / CLUT, and runs on the 6 MHz pixel clock.

Parameters:
LAYERS, 2, number of tile layers handled by this block (1..4)
BPP, 3, bits per pixel / bit planes per layer
CLW, 8, colour (palette bank) width
PRW, 3, priority width
TRANSP, {BPP{1'b1}}, pixel value treated as transparent

Ports:
CLK_6M  in  1  pixel clock; all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
FLIP  in  1  global flip: reverses pixel order within each 4-pixel group
LOAD  in  LAYERS  per-layer load strobe for one 4-pixel group
LAYER_EN  in  LAYERS  per-layer enable; 0 forces the layer transparent at the mixer
GDI  in  LAYERS*BPP*4  planar graphics; layer l at [l*BPP*4 +: BPP*4]; plane p at nibble [p*4 +: 4]
CLI_L  in  LAYERS*CLW  per-layer colour attribute, latched on LOAD
PRI_L  in  LAYERS*PRW  per-layer priority, latched on LOAD
FINE  in  LAYERS*2  per-layer fine-scroll delay of 0..3 pixels, sampled every cycle
PRI  in  PRW  upstream chain priority
CLI  in  CLW  upstream chain colour
DTI  in  BPP  upstream chain pixel
PRO  out  PRW  mixed priority
CLO  out  CLW  mixed colour
DTO  out  BPP  mixed pixel
ACTIVE  out  LAYERS  per-layer flag: group still shifting (stage-1 pixel valid)

Behaviour:
- Reset (async, RST_N=0):
  - PRO=0, CLO=0, DTO=0, ACTIVE=0.
  - All pixel, delay and chain registers hold TRANSP, or 0 for priority/colour fields.
  - Group counters are expired.
  - Takes effect immediately mid-line; the first output after release is chain data.
- Stage 1, per layer l, on each edge:
  - If LOAD[l]: latch GDI, CLI_L and PRI_L slices; set pixel index i=0; set ACTIVE[l]=1.
  - Else if ACTIVE[l] and i<3: i=i+1.
  - Else if i==3: ACTIVE[l]=0 and the layer pixel becomes TRANSP until the next LOAD.
  - LOAD while still shifting restarts the group (load wins); LOAD on every 4th cycle gives gapless output.
- Pixel extraction:
  - Bit p of pixel i = plane p nibble bit (3-i) when FLIP=0, bit i when FLIP=1.
  - FLIP is sampled combinationally each cycle, so a mid-group change applies immediately.
- Stage 1 also registers PRI/CLI/DTI into the chain register every edge.
- Fine delay:
  - Each layer's {pixel, colour, priority} passes through a 3-deep delay line.
  - The mixer taps stage FINE[l], where 0 means undelayed.
  - Delay line contents initialise to TRANSP at reset.
- Stage 2 mix (registered):
  - Start from the chain register. Iterate l=0..LAYERS-1.
  - Layer l replaces the current {PR,CL,DT} iff LAYER_EN[l]=1, its pixel != TRANSP, and PR_l >= current PR.
  - Equal priority therefore goes to the higher layer index. A chain pixel equal to TRANSP is still overridable by the same rule.
  - Register the result into PRO/CLO/DTO.
- Latency:
  - LOAD sampled at edge k: pixel 0 of that layer appears on DTO after edge k+1+FINE[l].
  - Chain input sampled at edge k appears after edge k+1. Chain and FINE=0 layers are therefore aligned.
- Width rules:
  - Priority comparison is unsigned PRW-bit; no arithmetic overflow paths.
  - Pixel index is 2 bits and does not wrap; it expires at 3.

Test Plan:
1. Serialisation: LAYERS=2, BPP=3, layer0 GDI=12'h0CA, CLI_L=8'h15, PRI_L=3, LOAD pulse at edge k, chain PRI=0 → DTO=3,2,1,0 after edges k+1..k+4, CLO=8'h15 and PRO=3 on those cycles, then chain data; ACTIVE[0] high for 4 cycles.
2. Flip plus gapless loads: FLIP=1, LOAD every 4th cycle with GDI=12'h0CA → continuous DTO 0,1,2,3,0,1,2,3 with no chain pixels between groups.
3. Transparency and enable: GDI=12'hFFF, or LAYER_EN[0]=0 with GDI=12'h0CA → DTO/CLO/PRO equal chain input (DTI=5, CLI=8'hA0, PRI=2) delayed 1 cycle.
4. Priority: layer0 PR=4, layer1 PR=4, both opaque and loaded together → layer1 wins (tie); then layer1 PR=2 → layer0 wins; chain PRI=5 → chain wins.
5. Fine scroll: layer0 FINE=2, layer1 FINE=0, both loaded at edge k → layer1 pixel 0 after k+1; layer0 pixel 0 after k+3.
6. Reset mid-group: drive RST_N=0 at pixel 2 → outputs 0 immediately. After release with no LOAD, output = chain input, with no stale layer pixels over the following 4 cycles.
